// File: rtl/lpb_pkg.sv
// Shared types and helpers for the burst-gated loopback buffer.
package lpb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } lpb_state_e;

    // Field ports are fixed at the top level; NUM_FIELDS selects how many are live.
    localparam int unsigned MAX_FIELDS = 8;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lpb_fifo.sv
// First-word fall-through FIFO; head entry is visible as soon as it is written.
module lpb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Data reads as zero whenever nothing is buffered, including during reset.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/lpb_burst_buffer.sv
// Burst-gated loopback buffer: ctrl tokens admit fixed-length bursts through a
// FWFT FIFO, and each fully drained burst returns one completion token.
module lpb_burst_buffer
    import lpb_pkg::*;
#(
    parameter int unsigned NUM_FIELDS      = 8,
    parameter int unsigned FIELD_W         = 64,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned BURST_LEN       = 16,
    parameter int unsigned MAX_CREDITS     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in0_valid,
    input  logic [FIELD_W-1:0] in0_data_field0,
    input  logic [FIELD_W-1:0] in0_data_field1,
    input  logic [FIELD_W-1:0] in0_data_field2,
    input  logic [FIELD_W-1:0] in0_data_field3,
    input  logic [FIELD_W-1:0] in0_data_field4,
    input  logic [FIELD_W-1:0] in0_data_field5,
    input  logic [FIELD_W-1:0] in0_data_field6,
    input  logic [FIELD_W-1:0] in0_data_field7,
    output logic               in0_ready,
    input  logic               inCtrl_valid,
    output logic               inCtrl_ready,
    output logic               out0_valid,
    output logic [FIELD_W-1:0] out0_data_field0,
    output logic [FIELD_W-1:0] out0_data_field1,
    output logic [FIELD_W-1:0] out0_data_field2,
    output logic [FIELD_W-1:0] out0_data_field3,
    output logic [FIELD_W-1:0] out0_data_field4,
    output logic [FIELD_W-1:0] out0_data_field5,
    output logic [FIELD_W-1:0] out0_data_field6,
    output logic [FIELD_W-1:0] out0_data_field7,
    input  logic               out0_ready,
    output logic               outCtrl_valid,
    input  logic               outCtrl_ready
);

    localparam int unsigned DATA_W = NUM_FIELDS * FIELD_W;
    localparam int unsigned CRED_W = cnt_w(MAX_CREDITS);
    localparam int unsigned OUTS_W = cnt_w(MAX_OUTSTANDING);
    localparam int unsigned BEAT_W = cnt_w(BURST_LEN);

    lpb_state_e        state;
    lpb_state_e        state_nxt;
    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] credits_nxt;
    logic [OUTS_W-1:0] outstanding;
    logic [OUTS_W-1:0] outstanding_nxt;
    logic [OUTS_W-1:0] done_cnt;
    logic [OUTS_W-1:0] done_cnt_nxt;
    logic [BEAT_W-1:0] in_cnt;
    logic [BEAT_W-1:0] in_cnt_nxt;
    logic [BEAT_W-1:0] out_cnt;
    logic [BEAT_W-1:0] out_cnt_nxt;
    logic              inctrl_rdy_q;
    logic              admit;
    logic              burst_done;
    logic              in_xfer;
    logic              out_xfer;
    logic              ictl_xfer;
    logic              octl_xfer;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] pop_data;
    logic [FIELD_W-1:0] in_fields  [MAX_FIELDS];
    logic [FIELD_W-1:0] out_fields [MAX_FIELDS];

    // Field ports <-> flat FIFO word
    assign in_fields[0] = in0_data_field0;
    assign in_fields[1] = in0_data_field1;
    assign in_fields[2] = in0_data_field2;
    assign in_fields[3] = in0_data_field3;
    assign in_fields[4] = in0_data_field4;
    assign in_fields[5] = in0_data_field5;
    assign in_fields[6] = in0_data_field6;
    assign in_fields[7] = in0_data_field7;

    always_comb begin
        push_data = '0;
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            push_data[i*FIELD_W +: FIELD_W] = in_fields[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < MAX_FIELDS; i++) begin
            out_fields[i] = '0;
        end
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            out_fields[i] = pop_data[i*FIELD_W +: FIELD_W];
        end
    end

    assign out0_data_field0 = out_fields[0];
    assign out0_data_field1 = out_fields[1];
    assign out0_data_field2 = out_fields[2];
    assign out0_data_field3 = out_fields[3];
    assign out0_data_field4 = out_fields[4];
    assign out0_data_field5 = out_fields[5];
    assign out0_data_field6 = out_fields[6];
    assign out0_data_field7 = out_fields[7];

    // Handshake decode; every ready/valid is a function of state flops only.
    assign in0_ready     = (state == ACTIVE) && !fifo_full;
    assign out0_valid    = !fifo_empty;
    assign outCtrl_valid = (done_cnt != '0);
    assign inCtrl_ready  = inctrl_rdy_q;

    assign in_xfer   = in0_valid && in0_ready;
    assign out_xfer  = out0_valid && out0_ready;
    assign ictl_xfer = inCtrl_valid && inCtrl_ready;
    assign octl_xfer = outCtrl_valid && outCtrl_ready;

    lpb_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_xfer),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (out_xfer),
        .pop_data  (pop_data),
        .empty     (fifo_empty)
    );

    // Ingress FSM: admit a burst, then accept exactly BURST_LEN beats.
    always_comb begin
        state_nxt = state;
        admit     = 1'b0;
        case (state)
            IDLE: begin
                if ((credits != '0) && (outstanding < OUTS_W'(MAX_OUTSTANDING))) begin
                    admit     = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (in_xfer && (in_cnt == BEAT_W'(BURST_LEN - 1))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Credit, outstanding and beat accounting
    always_comb begin
        credits_nxt     = credits;
        outstanding_nxt = outstanding;
        done_cnt_nxt    = done_cnt;
        in_cnt_nxt      = in_cnt;
        out_cnt_nxt     = out_cnt;
        burst_done      = 1'b0;

        if (ictl_xfer && !admit)      credits_nxt = credits + CRED_W'(1);
        else if (!ictl_xfer && admit) credits_nxt = credits - CRED_W'(1);

        if (admit && !octl_xfer)      outstanding_nxt = outstanding + OUTS_W'(1);
        else if (!admit && octl_xfer) outstanding_nxt = outstanding - OUTS_W'(1);

        if (admit)        in_cnt_nxt = '0;
        else if (in_xfer) in_cnt_nxt = in_cnt + BEAT_W'(1);

        if (out_xfer) begin
            if (out_cnt == BEAT_W'(BURST_LEN - 1)) begin
                out_cnt_nxt = '0;
                burst_done  = 1'b1;
            end else begin
                out_cnt_nxt = out_cnt + BEAT_W'(1);
            end
        end

        if (burst_done && !octl_xfer)      done_cnt_nxt = done_cnt + OUTS_W'(1);
        else if (!burst_done && octl_xfer) done_cnt_nxt = done_cnt - OUTS_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            credits      <= '0;
            outstanding  <= '0;
            done_cnt     <= '0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            inctrl_rdy_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            credits      <= credits_nxt;
            outstanding  <= outstanding_nxt;
            done_cnt     <= done_cnt_nxt;
            in_cnt       <= in_cnt_nxt;
            out_cnt      <= out_cnt_nxt;
            inctrl_rdy_q <= (credits_nxt < CRED_W'(MAX_CREDITS));
        end
    end

endmodule

// File: doc/lpb_burst_buffer.md
Name: lpb_burst_buffer

Overview:
- Parametrised successor to the loopback passthrough stage: a multi-field valid/ready data channel buffered by a DEPTH-entry FIFO, gated by a control-token channel.
- Each accepted inCtrl token admits one burst of BURST_LEN data beats. Each fully drained burst returns one outCtrl completion token.
- Sits between the host-side stream interface and the user loopback logic; gives flow control and burst accounting the plain passthrough lacks.

Parameters:
- NUM_FIELDS, 8, number of data fields per beat
- FIELD_W, 64, bits per field
- DEPTH, 4, FIFO entries; power of two, >= 2
- BURST_LEN, 16, beats per admitted burst; >= 1
- MAX_CREDITS, 4, max banked inCtrl tokens not yet consumed
- MAX_OUTSTANDING, 2, max bursts admitted whose completion token has not yet been handed off

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in0_valid  in  1  ingress beat valid
- in0_data_field0..field{NUM_FIELDS-1}  in  FIELD_W each  ingress fields
- in0_ready  out  1  ingress ready
- inCtrl_valid  in  1  burst-admission token valid
- inCtrl_ready  out  1  token ready
- out0_valid  out  1  egress beat valid
- out0_data_field0..field{NUM_FIELDS-1}  out  FIELD_W each  egress fields
- out0_ready  in  1  egress ready
- outCtrl_valid  out  1  completion token valid
- outCtrl_ready  in  1  completion token ready

Behaviour:
- Clocking/reset: one clock `clock`; reset `reset` is asynchronous and active-high. While reset is asserted, all state clears:
  - FIFO empty, credits=0, outstanding=0, done_cnt=0, beat counters=0, state=IDLE.
  - Outputs: in0_ready=0, inCtrl_ready=1 once reset has released (0 during reset), out0_valid=0, outCtrl_valid=0, data outputs=0.
  - Reset mid-burst discards buffered beats and pending tokens with no completion emitted.
- Handshake rule: a transfer occurs on a rising edge where valid&&ready. Valid, once raised, holds with stable data until accepted; the block guarantees this for out0 and outCtrl.
- Credit counter:
  - inCtrl_ready = credits < MAX_CREDITS.
  - +1 on inCtrl transfer, -1 on admission. Both in the same cycle leave the count unchanged.
- Ingress FSM:
  - IDLE: admission occurs when credits>0 && outstanding<MAX_OUTSTANDING. Admission consumes one credit, increments outstanding, clears in_cnt, and moves to ACTIVE next cycle.
  - ACTIVE: in0_ready = !fifo_full. Each in0 transfer writes the FIFO and increments in_cnt. The transfer taking in_cnt to BURST_LEN returns to IDLE next cycle.
  - in0_ready=0 in IDLE. One bubble cycle between bursts is permitted.
- FIFO (first-word fall-through):
  - out0_valid = !empty; the head entry drives out0 fields.
  - Latency: a beat written at edge t is visible on out0 after edge t.
  - Simultaneous push and pop when full is not allowed: ready is already low when full.
  - Simultaneous push and pop when neither full nor empty keeps occupancy constant.
  - Pointers wrap modulo DEPTH; full/empty use an extra wrap bit.
- Egress accounting:
  - out_cnt increments per out0 transfer. On the transfer making out_cnt==BURST_LEN, out_cnt clears and done_cnt increments.
  - outCtrl_valid = done_cnt>0. Each outCtrl transfer decrements both done_cnt and outstanding.
  - Simultaneous burst completion and outCtrl transfer leave done_cnt unchanged and decrement outstanding.
  - Invariant: done_cnt <= outstanding <= MAX_OUTSTANDING. No overflow is possible.
- Counter widths: $clog2(N+1) for credits, outstanding and done_cnt; $clog2(BURST_LEN+1) for in_cnt and out_cnt.

Decomposition:
- Package lpb_pkg holds:
  - the state enum (IDLE, ACTIVE);
  - helper function cnt_w(n) = $clog2(n+1).
- Sub-module lpb_fifo: generic FWFT FIFO with parameters WIDTH and DEPTH and ports push/full/pop/empty.
  - Data fields are packed into one NUM_FIELDS*FIELD_W vector at the top level and unpacked on output.

Test Plan:
- Reset with all inputs idle: in0_ready=0, out0_valid=0, outCtrl_valid=0, inCtrl_ready=1. Assert reset while 3 beats are buffered: all outputs drop immediately (asynchronously).
- One inCtrl token, then 16 beats with field0=i (0..15), out0_ready=1:
  - out0 delivers field0 0..15 in order, each 1 cycle after acceptance;
  - one outCtrl_valid pulse appears after the 16th egress beat;
  - in0_ready=0 after beat 15 is accepted.
- Backpressure with out0_ready=0, one token, 16 beats offered: exactly 4 beats accepted (DEPTH=4), then in0_ready=0. Raising out0_ready drains all 16 in order.
- Send 6 tokens with inCtrl_valid held:
  - inCtrl_ready drops after 4 are banked; it rises again once the first admission consumes a credit;
  - with outCtrl_ready=0, only 2 bursts are admitted (MAX_OUTSTANDING=2); a third burst is admitted only after an outCtrl transfer.
- Same-cycle 16th egress beat and outCtrl handshake of the prior burst: done_cnt stays 1, outstanding goes 2->1, outCtrl_valid stays 1.
- Random valid/ready toggling (50%) over 20 bursts: data matches a scoreboard, exactly 20 outCtrl tokens, no beat accepted outside ACTIVE.
